alu_seq_hs: RTL and testbench
=============================

// Module: alu_seq_hs
// PURPOSE
//  Parametrised, handshaked successor to the 32-bit combinational ALU. Adds
//  registered results and flags, valid/ready flow control and an iterative
//  shift-add multiplier, plus saturating add/sub and signed MAX/MIN.
//  Sits between the operand issue stage and writeback; one operation in flight.
// PARAMETERS
//  WIDTH   32  operand/result width in bits (>=8, power of 2)
//  SHW     $clog2(WIDTH)  rotate-amount width (derived, not overridden)
// PORTS
//  clk          in   1      single clock, rising edge
//  reset        in   1      synchronous, active-high reset
//  in_valid     in   1      operands/op valid
//  in_ready     out  1      block can accept an op this cycle
//  input1       in   WIDTH  operand A
//  input2       in   WIDTH  operand B
//  shiftValue   in   SHW    rotate amount (ROL/ROR only)
//  ALUSel       in   4      opcode (encodings below)
//  out_valid    out  1      result/flags valid
//  out_ready    in   1      consumer takes result
//  result       out  WIDTH  registered result
//  carryFlag, zeroFlag, overFlowFlag, signFlag  out 1 each, registered with result
// BEHAVIOUR
//  Opcodes: ADD0 SUB1 MUL2 ROL3 ROR4 NEG5 ABS6 MAX7 MIN8 (unchanged) plus
//   SADD9 SSUB10 SMAX11 SMIN12; 13-15 illegal -> result 0, C=V=0.
//  Reset: state IDLE; out_valid=0, result=0, all flags 0, mul regs 0.
//   Reset wins over any in-flight op (MUL aborted, pending result dropped).
//  FSM: IDLE -> (accept, op!=MUL) -> DONE; IDLE -> (accept, MUL) -> MUL_BUSY;
//   MUL_BUSY -> after WIDTH iterations -> DONE; DONE -> (out_ready) -> IDLE,
//   or directly to DONE/MUL_BUSY if a new op is accepted the same cycle.
//  Accept = in_valid && in_ready. in_ready = IDLE || (DONE && out_ready).
//  Latency: non-MUL out_valid 1 cycle after accept; MUL out_valid WIDTH+1
//   cycles after accept. Back-to-back non-MUL ops: 1 op/cycle throughput.
//  out_valid=1 only in DONE; result/flags held stable while out_valid &&
//   !out_ready. Operands latched at accept; inputs ignored otherwise.
//  Arithmetic: ADD/SUB via WIDTH+1 adder (SUB = A+~B+1). C = adder carry-out
//   for ADD/SUB/SADD/SSUB, else 0. V = signed overflow for ADD/SUB; for
//   SADD/SSUB V=1 iff saturation occurred; else 0.
//  SADD/SSUB clamp to signed max 0x7F..F / min 0x80..0 on overflow.
//  MUL: low WIDTH bits of unsigned product, 1 partial product/cycle, LSB first.
//  ROL/ROR: shiftValue=0 -> result=input1 (no shift-by-WIDTH).
//  NEG: two's complement; NEG/ABS of 0x80..0 -> 0x80..0, V=0.
//  MAX/MIN unsigned compare; SMAX/SMIN signed; equal operands -> input1.
//  Z = (result==0), S = result[WIDTH-1], both for every opcode incl. illegal.
// STRUCTURE
//  Package alu_seq_pkg: opcode localparams/enum (4-bit), FSM state enum
//   (IDLE, MUL_BUSY, DONE), flag struct {c,z,v,s}.
//  Sub-module alu_seq_mul: iterative shift-add multiplier, start/busy/done,
//   WIDTH param, synchronous reset. Remaining datapath combinational in top.
// TESTING (WIDTH=32 unless noted)
//  ADD 0x7FFFFFFF+1 -> result 0x80000000, V=1 C=0 S=1, out_valid 1 cycle later
//  SADD 0x7FFFFFFF+1 -> 0x7FFFFFFF V=1; SSUB 0x80000000-1 -> 0x80000000 V=1
//  MUL 0x0000FFFF*0x00010001 -> 0xFFFFFFFF after 33 cycles; in_ready=0 while busy
//  ROL 0x80000001 by 1 -> 0x00000003; ROR by 0 -> unchanged; SMAX(-1,1)->1, MAX->0xFFFFFFFF
//  Backpressure: out_ready=0 for 5 cycles -> result/flags stable, in_ready=0;
//   then ready+new ADD same cycle -> next result 1 cycle later, no bubble
//  Reset asserted mid-MUL (cycle 10) -> next cycle out_valid=0, result=0,
//   in_ready=1; rerun WIDTH=8: MUL 15*17 -> 0xFF after 9 cycles

Source files
------------

// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
// Shared types for the handshaked sequential ALU:
//   alu_op_e  - 4-bit opcode encoding (13..15 are illegal)
//   state_e   - control FSM states
//   flags_t   - registered condition flags {c, z, v, s}
// -----------------------------------------------------------------------------
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MUL  = 4'd2,
        OP_ROL  = 4'd3,
        OP_ROR  = 4'd4,
        OP_NEG  = 4'd5,
        OP_ABS  = 4'd6,
        OP_MAX  = 4'd7,
        OP_MIN  = 4'd8,
        OP_SADD = 4'd9,
        OP_SSUB = 4'd10,
        OP_SMAX = 4'd11,
        OP_SMIN = 4'd12
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        DONE     = 2'd2
    } state_e;

    typedef struct packed {
        logic c;
        logic z;
        logic v;
        logic s;
    } flags_t;

endpackage

// File: rtl/alu_seq_mul.sv
// -----------------------------------------------------------------------------
// alu_seq_mul
// Iterative shift-add multiplier, one partial product per cycle, LSB first.
// Returns the low WIDTH bits of the unsigned product.
//   clk, reset   - clock, synchronous active-high reset
//   start        - load operands a/b and begin (ignored while busy by caller)
//   a, b         - multiplicand / multiplier
//   busy         - iterations in progress
//   done         - high during the final iteration cycle
//   product      - final product, valid while done is high
// -----------------------------------------------------------------------------
module alu_seq_mul #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] acc_step;

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

        if (start) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
                busy_d = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the datapath registers are cleared on reset as well as the
            // control bits, so an aborted multiply leaves nothing behind.
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    // The last partial product is folded in combinationally so the caller can
    // register the finished product on the same edge as the last iteration.
    assign busy    = busy_q;
    assign done    = busy_q && (cnt_q == LAST_CNT);
    assign product = acc_step;

endmodule

// File: rtl/alu_seq_hs.sv
// -----------------------------------------------------------------------------
// alu_seq_hs
// Handshaked ALU with registered result/flags, one operation in flight.
// Non-MUL ops complete in one cycle; MUL uses the iterative multiplier.
//   clk, reset          - clock, synchronous active-high reset
//   in_valid / in_ready - operand handshake (accept = in_valid && in_ready)
//   input1, input2      - operands A and B
//   shiftValue          - rotate amount for ROL/ROR
//   ALUSel              - 4-bit opcode
//   out_valid/out_ready - result handshake (out_valid only in DONE)
//   result, carryFlag, zeroFlag, overFlowFlag, signFlag - registered outputs
// -----------------------------------------------------------------------------
module alu_seq_hs
    import alu_seq_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic [SHW-1:0]   shiftValue,
    input  logic [3:0]       ALUSel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carryFlag,
    output logic             zeroFlag,
    output logic             overFlowFlag,
    output logic             signFlag
);

    localparam int MSB = WIDTH - 1;
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] SMAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    flags_t           flags_q, flags_d;

    logic             accept;
    logic             mul_start;
    logic             mul_busy;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    // Combinational datapath for every opcode except MUL
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     sub_diff;
    logic               add_ovf;
    logic               sub_ovf;
    logic [WIDTH-1:0]   neg_val;
    logic [2*WIDTH-1:0] rot_l;
    logic [2*WIDTH-1:0] rot_r;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic               alu_v;
    flags_t             alu_flags;
    flags_t             mul_flags;

    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (input1),
        .b       (input2),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        add_sum  = {1'b0, input1} + {1'b0, input2};
        sub_diff = {1'b0, input1} + {1'b0, ~input2} + {{WIDTH{1'b0}}, 1'b1};
        add_ovf  = (input1[MSB] == input2[MSB]) && (add_sum[MSB] != input1[MSB]);
        sub_ovf  = (input1[MSB] != input2[MSB]) && (sub_diff[MSB] != input1[MSB]);
        neg_val  = ~input1 + ONE;
        // Rotating a doubled copy gives the wrap-around for free and makes a
        // zero amount a plain pass-through.
        rot_l    = {input1, input1} << shiftValue;
        rot_r    = {input1, input1} >> shiftValue;

        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;

        case (ALUSel)
            OP_ADD: begin
                alu_res = add_sum[MSB:0];
                alu_c   = add_sum[WIDTH];
                alu_v   = add_ovf;
            end
            OP_SUB: begin
                alu_res = sub_diff[MSB:0];
                alu_c   = sub_diff[WIDTH];
                alu_v   = sub_ovf;
            end
            OP_SADD: begin
                alu_c   = add_sum[WIDTH];
                alu_v   = add_ovf;
                // Overflow direction follows the operands' common sign.
                alu_res = add_ovf ? (input1[MSB] ? SMIN_VAL : SMAX_VAL) : add_sum[MSB:0];
            end
            OP_SSUB: begin
                alu_c   = sub_diff[WIDTH];
                alu_v   = sub_ovf;
                alu_res = sub_ovf ? (input1[MSB] ? SMIN_VAL : SMAX_VAL) : sub_diff[MSB:0];
            end
            OP_MUL:  alu_res = '0;  // produced by the multiplier instead
            OP_ROL:  alu_res = rot_l[2*WIDTH-1:WIDTH];
            OP_ROR:  alu_res = rot_r[MSB:0];
            OP_NEG:  alu_res = neg_val;
            OP_ABS:  alu_res = input1[MSB] ? neg_val : input1;
            OP_MAX:  alu_res = (input1 >= input2) ? input1 : input2;
            OP_MIN:  alu_res = (input1 <= input2) ? input1 : input2;
            OP_SMAX: alu_res = ($signed(input1) >= $signed(input2)) ? input1 : input2;
            OP_SMIN: alu_res = ($signed(input1) <= $signed(input2)) ? input1 : input2;
            default: alu_res = '0;
        endcase

        alu_flags.c = alu_c;
        alu_flags.z = (alu_res == '0);
        alu_flags.v = alu_v;
        alu_flags.s = alu_res[MSB];

        mul_flags.c = 1'b0;
        mul_flags.z = (mul_product == '0);
        mul_flags.v = 1'b0;
        mul_flags.s = mul_product[MSB];
    end

    // Handshake: a held result can be retired and replaced in the same cycle.
    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (ALUSel == OP_MUL);
    assign out_valid = (state_q == DONE);

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;

        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    if (ALUSel == OP_MUL) begin
                        state_d = MUL_BUSY;
                    end else begin
                        state_d  = DONE;
                        result_d = alu_res;
                        flags_d  = alu_flags;
                    end
                end else if ((state_q == DONE) && out_ready) begin
                    state_d = IDLE;
                end
            end
            MUL_BUSY: begin
                if (mul_done) begin
                    state_d  = DONE;
                    result_d = mul_product;
                    flags_d  = mul_flags;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign result       = result_q;
    assign carryFlag    = flags_q.c;
    assign zeroFlag     = flags_q.z;
    assign overFlowFlag = flags_q.v;
    assign signFlag     = flags_q.s;

endmodule

// File: tb/tb_alu_seq_hs.sv
// -----------------------------------------------------------------------------
// tb_alu_seq_hs
// Directed bench for alu_seq_hs at WIDTH=32 plus a WIDTH=8 instance for the
// short multiply. Flags are compared as the nibble {C, Z, V, S}.
// -----------------------------------------------------------------------------
module tb_alu_seq_hs;
    import alu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset;

    // WIDTH=32 instance
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] input1, input2, result;
    logic [4:0]  shiftValue;
    logic [3:0]  ALUSel;
    logic        carryFlag, zeroFlag, overFlowFlag, signFlag;

    // WIDTH=8 instance
    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0]  input1_8, input2_8, result8;
    logic [2:0]  shiftValue8;
    logic [3:0]  ALUSel8;
    logic        carry8, zero8, ovf8, sign8;

    int checks = 0;
    int errors = 0;

    alu_seq_hs #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .input1(input1), .input2(input2), .shiftValue(shiftValue), .ALUSel(ALUSel),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .carryFlag(carryFlag), .zeroFlag(zeroFlag),
        .overFlowFlag(overFlowFlag), .signFlag(signFlag)
    );

    alu_seq_hs #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .input1(input1_8), .input2(input2_8), .shiftValue(shiftValue8), .ALUSel(ALUSel8),
        .out_valid(out_valid8), .out_ready(out_ready8), .result(result8),
        .carryFlag(carry8), .zeroFlag(zero8),
        .overFlowFlag(ovf8), .signFlag(sign8)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] flags32();
        return {carryFlag, zeroFlag, overFlowFlag, signFlag};
    endfunction

    // Issue one single-cycle op with out_ready high; check 1-cycle latency.
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                          input logic [31:0] exp_res, input logic [3:0] exp_flg);
        @(negedge clk);
        check({tag, " in_ready"}, in_ready, 1);
        in_valid   = 1'b1;
        ALUSel     = op;
        input1     = a;
        input2     = b;
        shiftValue = sh;
        @(negedge clk);
        in_valid = 1'b0;
        input1   = 32'hDEAD_BEEF;
        input2   = 32'h0BAD_F00D;
        check({tag, " out_valid"}, out_valid, 1);
        check({tag, " result"}, result, exp_res);
        check({tag, " flags"}, flags32(), exp_flg);
    endtask

    initial begin
        logic stable;
        logic busy_ready;
        logic ghost;
        int   lat;

        reset = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1;
        input1 = '0; input2 = '0; shiftValue = '0; ALUSel = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b1;
        input1_8 = '0; input2_8 = '0; shiftValue8 = '0; ALUSel8 = '0;
        repeat (2) @(negedge clk);
        check("reset out_valid", out_valid, 0);
        check("reset in_ready", in_ready, 1);
        check("reset result", result, 0);
        check("reset flags", flags32(), 4'b0000);
        reset = 1'b0;

        // Single-cycle ops: expected flags are {C,Z,V,S}
        run_op("add ovf",    OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 32'h8000_0000, 4'b0011);
        run_op("add wrap",   OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 32'h0000_0000, 4'b1100);
        run_op("sub zero",   OP_SUB,  32'h0000_0005, 32'h0000_0005, 5'd0, 32'h0000_0000, 4'b1100);
        run_op("sub borrow", OP_SUB,  32'h0000_0000, 32'h0000_0001, 5'd0, 32'hFFFF_FFFF, 4'b0001);
        run_op("sadd sat+",  OP_SADD, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 32'h7FFF_FFFF, 4'b0010);
        run_op("sadd sat-",  OP_SADD, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 32'h8000_0000, 4'b1011);
        run_op("sadd plain", OP_SADD, 32'h0000_0003, 32'h0000_0004, 5'd0, 32'h0000_0007, 4'b0000);
        run_op("ssub sat-",  OP_SSUB, 32'h8000_0000, 32'h0000_0001, 5'd0, 32'h8000_0000, 4'b1011);
        run_op("rol 1",      OP_ROL,  32'h8000_0001, 32'h0,         5'd1, 32'h0000_0003, 4'b0000);
        run_op("ror 0",      OP_ROR,  32'h1234_5678, 32'h0,         5'd0, 32'h1234_5678, 4'b0000);
        run_op("ror 4",      OP_ROR,  32'h0000_0001, 32'h0,         5'd4, 32'h1000_0000, 4'b0000);
        run_op("smax",       OP_SMAX, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 32'h0000_0001, 4'b0000);
        run_op("max",        OP_MAX,  32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 32'hFFFF_FFFF, 4'b0001);
        run_op("min",        OP_MIN,  32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 32'h0000_0001, 4'b0000);
        run_op("smin",       OP_SMIN, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 32'hFFFF_FFFF, 4'b0001);
        run_op("neg min",    OP_NEG,  32'h8000_0000, 32'h0,         5'd0, 32'h8000_0000, 4'b0001);
        run_op("neg 1",      OP_NEG,  32'h0000_0001, 32'h0,         5'd0, 32'hFFFF_FFFF, 4'b0001);
        run_op("abs min",    OP_ABS,  32'h8000_0000, 32'h0,         5'd0, 32'h8000_0000, 4'b0001);
        run_op("abs -5",     OP_ABS,  32'hFFFF_FFFB, 32'h0,         5'd0, 32'h0000_0005, 4'b0000);
        run_op("illegal",    4'd13,   32'h0000_0005, 32'h0000_0003, 5'd0, 32'h0000_0000, 4'b0100);

        // MUL: result WIDTH+1 cycles after accept, in_ready low meanwhile
        @(negedge clk);
        in_valid = 1'b1; ALUSel = OP_MUL;
        input1 = 32'h0000_FFFF; input2 = 32'h0001_0001;
        lat = 0; busy_ready = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (i == 1) begin
                in_valid = 1'b0; input1 = 32'h1111_1111; input2 = 32'h2222_2222;
            end
            if (out_valid) begin
                lat = i;
                break;
            end
            if (in_ready) busy_ready = 1'b1;
        end
        check("mul latency", lat, 33);
        check("mul in_ready busy", busy_ready, 0);
        check("mul result", result, 32'hFFFF_FFFF);
        check("mul flags", flags32(), 4'b0001);

        // Backpressure: result held while out_ready is low
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; ALUSel = OP_ADD; input1 = 32'd10; input2 = 32'd20;
        @(negedge clk);
        check("bp out_valid", out_valid, 1);
        check("bp result", result, 32'd30);
        input1 = 32'd1; input2 = 32'd2;   // offered but must not be taken
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!out_valid || result !== 32'd30 || flags32() !== 4'b0000 || in_ready)
                stable = 1'b0;
        end
        check("bp hold", stable, 1);
        out_ready = 1'b1;
        input1 = 32'd100; input2 = 32'd200;
        #1;
        check("bp in_ready release", in_ready, 1);
        @(negedge clk);
        check("bp next valid", out_valid, 1);
        check("bp next result", result, 32'd300);
        in_valid = 1'b0;
        @(negedge clk);
        check("bp drained", out_valid, 0);

        // Reset in the middle of a multiply
        in_valid = 1'b1; ALUSel = OP_MUL; input1 = 32'd3; input2 = 32'd5;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) in_valid = 1'b0;
        end
        check("rst mid busy", in_ready, 0);
        reset = 1'b1;
        @(negedge clk);
        check("rst out_valid", out_valid, 0);
        check("rst result", result, 0);
        check("rst in_ready", in_ready, 1);
        check("rst flags", flags32(), 4'b0000);
        reset = 1'b0;
        ghost = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) ghost = 1'b1;
        end
        check("rst mul aborted", ghost, 0);

        // WIDTH=8: 15*17 = 0xFF after 9 cycles
        @(negedge clk);
        check("w8 in_ready", in_ready8, 1);
        in_valid8 = 1'b1; ALUSel8 = OP_MUL; input1_8 = 8'd15; input2_8 = 8'd17;
        lat = 0; busy_ready = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 1) begin
                in_valid8 = 1'b0; input1_8 = 8'h00; input2_8 = 8'h00;
            end
            if (out_valid8) begin
                lat = i;
                break;
            end
            if (in_ready8) busy_ready = 1'b1;
        end
        check("w8 mul latency", lat, 9);
        check("w8 mul in_ready busy", busy_ready, 0);
        check("w8 mul result", result8, 8'hFF);
        check("w8 mul flags", {carry8, zero8, ovf8, sign8}, 4'b0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
